// File: rtl/signed_add_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : signed_add_pipe_stage
// Purpose  : Registered signed adder with valid/ready handshake, 2-entry skid
//            buffer, overflow detection, sticky overflow flag and saturating
//            operation counter. Optional macro SIGNED_ADD_SAT_EN: clamp the
//            stored sum to the signed limit on overflow.
// Revision : 1.0 - initial release
// ============================================================================
module signed_add_pipe_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s_add,
  output logic             s_ovf,
  input  logic             clr,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] C_MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] C_MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q;
  logic [WIDTH-1:0] head_sum_q;
  logic             head_ovf_q;
  logic [WIDTH-1:0] tail_sum_q;
  logic             tail_ovf_q;
  logic             ovf_sticky_q;
  logic             ovf_sticky_d;
  logic [CNT_W-1:0] op_count_q;
  logic [CNT_W-1:0] op_count_d;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] sum_raw;
  logic             ovf;
  logic [WIDTH-1:0] sum_store;

  // Ready depends on state alone so no combinational path from out_ready.
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign sum_raw = num1 + num2;
  assign ovf     = (num1[WIDTH-1] == num2[WIDTH-1]) &
                   (sum_raw[WIDTH-1] != num1[WIDTH-1]);

  always_comb begin
    sum_store = sum_raw;
`ifdef SIGNED_ADD_SAT_EN
    if (ovf) begin
      sum_store = num1[WIDTH-1] ? C_MIN_NEG : C_MAX_POS;
    end
`else
    if (ovf) begin
      sum_store = sum_raw;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      head_sum_q <= '0;
      head_ovf_q <= 1'b0;
      tail_sum_q <= '0;
      tail_ovf_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            head_sum_q <= sum_store;
            head_ovf_q <= ovf;
            state_q    <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_sum_q <= sum_store;
            head_ovf_q <= ovf;
          end else if (push) begin
            tail_sum_q <= sum_store;
            tail_ovf_q <= ovf;
            state_q    <= TWO;
          end else if (pop) begin
            state_q    <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            head_sum_q <= tail_sum_q;
            head_ovf_q <= tail_ovf_q;
            state_q    <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  // Clear is applied first so a coincident push still registers (set wins).
  always_comb begin
    ovf_sticky_d = (clr ? 1'b0 : ovf_sticky_q) | (push & ovf);
    op_count_d   = clr ? '0 : op_count_q;
    if (push && (op_count_d != C_CNT_MAX)) begin
      op_count_d = op_count_d + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky_q <= 1'b0;
      op_count_q   <= '0;
    end else begin
      ovf_sticky_q <= ovf_sticky_d;
      op_count_q   <= op_count_d;
    end
  end

  assign s_add      = head_sum_q;
  assign s_ovf      = head_ovf_q;
  assign ovf_sticky = ovf_sticky_q;
  assign op_count   = op_count_q;

endmodule
`default_nettype wire

// File: tb/tb_signed_add_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_signed_add_pipe_stage
// Purpose  : Directed self-checking bench for signed_add_pipe_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_signed_add_pipe_stage;

  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] num1;
  logic [WIDTH-1:0] num2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s_add;
  logic             s_ovf;
  logic             clr;
  logic             ovf_sticky;
  logic [CNT_W-1:0] op_count;

  int checks;
  int errors;

  signed_add_pipe_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num1      (num1),
    .num2      (num2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s_add     (s_add),
    .s_ovf     (s_ovf),
    .clr       (clr),
    .ovf_sticky(ovf_sticky),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0;
    num1 = '0; num2 = '0;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (s_add !== 32'h0 || s_ovf !== 1'b0) begin errors++; $display("FAIL reset_head got %h/%b exp 0/0", s_add, s_ovf); end
    checks++; if (ovf_sticky !== 1'b0 || op_count !== 16'd0) begin errors++; $display("FAIL reset_status got %b/%0d exp 0/0", ovf_sticky, op_count); end
    rst = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    in_valid = 1'b1; num1 = 32'd1010; num2 = 32'd1000;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || s_add !== 32'd2010 || s_ovf !== 1'b0) begin errors++; $display("FAIL basic_sum got v=%b %0d ovf=%b exp v=1 2010 ovf=0", out_valid, s_add, s_ovf); end
    checks++; if (op_count !== 16'd1) begin errors++; $display("FAIL basic_count got %0d exp 1", op_count); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_negative();
    in_valid = 1'b1; num1 = 32'hFFF0_B8DB; num2 = 32'hFFFB_F998;  // -1001253 + -263784
    step();
    checks++; if (s_add !== 32'hFFEC_B273 || s_ovf !== 1'b0) begin errors++; $display("FAIL neg_sum1 got %h/%b exp ffecb273/0", s_add, s_ovf); end
    num1 = 32'd263; num2 = 32'hFFFF_9509;  // 263 + -27383
    step();
    in_valid = 1'b0;
    checks++; if (s_add !== 32'hFFFF_9610 || s_ovf !== 1'b0) begin errors++; $display("FAIL neg_sum2 got %h/%b exp ffff9610/0", s_add, s_ovf); end
    checks++; if (ovf_sticky !== 1'b0 || op_count !== 16'd3) begin errors++; $display("FAIL neg_status got %b/%0d exp 0/3", ovf_sticky, op_count); end
    step();
  endtask

  task automatic test_overflow();
    logic [WIDTH-1:0] exp_pos;
    logic [WIDTH-1:0] exp_neg;
`ifdef SIGNED_ADD_SAT_EN
    exp_pos = 32'h7FFF_FFFF; exp_neg = 32'h8000_0000;
`else
    exp_pos = 32'h8000_0000; exp_neg = 32'h7FFF_FFFF;
`endif
    in_valid = 1'b1; num1 = 32'h7FFF_FFFF; num2 = 32'd1;
    step();
    checks++; if (s_add !== exp_pos || s_ovf !== 1'b1) begin errors++; $display("FAIL pos_ovf got %h/%b exp %h/1", s_add, s_ovf, exp_pos); end
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL pos_ovf_sticky got %b exp 1", ovf_sticky); end
    num1 = 32'h8000_0000; num2 = 32'hFFFF_FFFF;
    step();
    checks++; if (s_add !== exp_neg || s_ovf !== 1'b1) begin errors++; $display("FAIL neg_ovf got %h/%b exp %h/1", s_add, s_ovf, exp_neg); end
    num1 = 32'h7FFF_FFFF; num2 = 32'h8000_0000;  // mixed signs never overflow
    step();
    in_valid = 1'b0;
    checks++; if (s_add !== 32'hFFFF_FFFF || s_ovf !== 1'b0 || op_count !== 16'd6) begin errors++; $display("FAIL mixed_sign got %h/%b cnt=%0d exp ffffffff/0 cnt=6", s_add, s_ovf, op_count); end
    step();
  endtask

  task automatic test_back_to_back();
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++; if (ovf_sticky !== 1'b0 || op_count !== 16'd0) begin errors++; $display("FAIL clr_alone got %b/%0d exp 0/0", ovf_sticky, op_count); end
    out_ready = 1'b0;
    in_valid = 1'b1; num1 = 32'd1; num2 = 32'd1;
    step();
    checks++; if (in_ready !== 1'b1 || s_add !== 32'd2) begin errors++; $display("FAIL bp_first got rdy=%b %0d exp rdy=1 2", in_ready, s_add); end
    num1 = 32'd2; num2 = 32'd2;
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full got rdy=%b exp 0", in_ready); end
    num1 = 32'd3; num2 = 32'd3;
    step();
    checks++; if (in_ready !== 1'b0 || s_add !== 32'd2 || op_count !== 16'd2) begin errors++; $display("FAIL bp_hold got rdy=%b %0d cnt=%0d exp rdy=0 2 cnt=2", in_ready, s_add, op_count); end
    out_ready = 1'b1;
    step();
    checks++; if (s_add !== 32'd4 || out_valid !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_second got %0d v=%b rdy=%b exp 4 v=1 rdy=1", s_add, out_valid, in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (s_add !== 32'd6 || op_count !== 16'd3) begin errors++; $display("FAIL bp_third got %0d cnt=%0d exp 6 cnt=3", s_add, op_count); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_clear();
    in_valid = 1'b1; clr = 1'b1; num1 = 32'h7FFF_FFFF; num2 = 32'd1;
    step();
    in_valid = 1'b0; clr = 1'b0;
    checks++; if (ovf_sticky !== 1'b1 || op_count !== 16'd1) begin errors++; $display("FAIL clr_push got %b/%0d exp 1/1", ovf_sticky, op_count); end
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++; if (ovf_sticky !== 1'b0 || op_count !== 16'd0) begin errors++; $display("FAIL clr_later got %b/%0d exp 0/0", ovf_sticky, op_count); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; num1 = 32'd10; num2 = 32'd20;
    step();
    num1 = 32'd30;
    step();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || op_count !== 16'd2) begin errors++; $display("FAIL mid_full got rdy=%b v=%b cnt=%0d exp 0 1 2", in_ready, out_valid, op_count); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_count !== 16'd0) begin errors++; $display("FAIL mid_async_rst got v=%b rdy=%b cnt=%0d exp 0 1 0", out_valid, in_ready, op_count); end
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_after got v=%b rdy=%b exp 0 1", out_valid, in_ready); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_negative();
    test_overflow();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/signed_add_pipe_stage.md
Name: signed_add_pipe_stage

Overview:
- Registered, flow-controlled wrapper around the team's 32-bit signed two's-complement adder.
- Accepts operand pairs over a valid/ready handshake and computes num1+num2 with signed-overflow detection.
- Buffers results in a 2-entry skid buffer, so downstream consumers (accumulators, ALU writeback) can stall without losing data.
- Also keeps a sticky overflow flag and a saturating count of completed operations for status reads.

Parameters:
- WIDTH, 32, operand/result width in bits (two's complement)
- CNT_W, 16, width of operation counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  stage can accept operand pair
- num1  input  WIDTH  signed operand A
- num2  input  WIDTH  signed operand B
- out_valid  output  1  result valid at head of buffer
- out_ready  input  1  downstream accepts result
- s_add  output  WIDTH  signed sum at head of buffer
- s_ovf  output  1  overflow flag for head result
- clr  input  1  synchronous clear of status (ovf_sticky, op_count)
- ovf_sticky  output  1  set by any accepted overflowing operation
- op_count  output  CNT_W  number of accepted operations, saturating

Behaviour:
- Reset (async, active-high) forces the following; the buffer contents are discarded.
  - state=EMPTY, out_valid=0, s_add=0, s_ovf=0
  - ovf_sticky=0, op_count=0
  - in_ready=1 once rst deasserts
- push = in_valid & in_ready; pop = out_valid & out_ready.
- Sum: sum = num1 + num2, modulo 2^WIDTH.
- Overflow: ovf = (num1[MSB]==num2[MSB]) & (sum[MSB]!=num1[MSB]).
- Result is computed combinationally at acceptance; the entry is written on the push edge.
- Latency: a result accepted on edge N is visible at s_add/out_valid after edge N (1 cycle).
- Buffer states and transitions:
  - EMPTY: push -> ONE (head=new entry).
  - ONE: push&!pop -> TWO (tail=new); !push&pop -> EMPTY; push&pop -> ONE (head=new); neither -> ONE.
  - TWO: pop -> ONE (head<=tail); no pop -> TWO. Push is impossible here because in_ready=0.
- in_ready = (state != TWO). It is a function of state only, with no combinational path from out_ready.
- out_valid = (state != EMPTY).
- s_add/s_ovf always reflect the head entry. They are held stable while out_valid=1 and out_ready=0.
- In EMPTY, s_add/s_ovf retain their last value. They are don't-care to consumers.
- ovf_sticky:
  - Set on any push whose ovf=1.
  - Cleared by clr.
  - If clr and an overflowing push occur in the same cycle, set wins (ovf_sticky=1).
- op_count:
  - Increments by 1 on each push and saturates at 2^CNT_W-1 (no wrap).
  - clr sets it to 0. If clr and push occur in the same cycle, the result is 1.
- clr does not affect buffer contents or handshake.
- Reset mid-transfer: buffered results are lost. The upstream must not assume completion of unacknowledged pushes.

Optional Feature:
- Macro: SIGNED_ADD_SAT_EN.
- Defined: on ovf, the stored sum saturates to the signed limit, and s_ovf/ovf_sticky still report the overflow.
  - Operands positive -> 0x7FFFFFFF (max positive).
  - Operands negative -> 0x80000000 (min negative).
- Undefined: wrap-around (modulo) result is stored.

Test Plan:
- Basic sum: num1=1010, num2=1000, out_ready=1 -> next cycle s_add=2010, s_ovf=0, op_count=1.
- Negative operands: num1=-1001253, num2=-263784 -> s_add=32'hFFECB273 (-1265037), s_ovf=0. Also check num1=263, num2=-27383 -> s_add=-27120.
- Positive overflow: num1=32'h7FFFFFFF, num2=1.
  - Macro undefined -> s_add=32'h80000000, s_ovf=1, ovf_sticky=1.
  - SIGNED_ADD_SAT_EN defined -> s_add=32'h7FFFFFFF.
- Negative overflow: num1=32'h80000000, num2=32'hFFFFFFFF.
  - Macro undefined -> s_add=32'h7FFFFFFF, s_ovf=1.
  - SIGNED_ADD_SAT_EN defined -> 32'h80000000.
- Backpressure: out_ready=0, push 3 pairs back-to-back (1+1, 2+2, 3+3).
  - in_ready drops after 2 accepts and the third stays held.
  - Raise out_ready -> results 2, 4, 6 in order, none lost, op_count=3.
- Clear/reset: overflowing push with clr in the same cycle -> ovf_sticky=1, op_count=1.
  - Later clr alone -> both 0.
  - Assert rst with 2 entries buffered -> out_valid=0, in_ready=1, op_count=0 immediately (async).
